// File: rtl/id_operand_stage.sv
// ---------------------------------------------------------------------------
// id_operand_stage
//   Decode / operand-fetch stage sitting directly upstream of the register
//   file. Drives the two read addresses combinationally from the incoming
//   instruction and captures the returned operands with write-back bypass.
//   It stalls on load-use hazards against the EX stage and presents a
//   registered ID/EX bundle over a valid/ready handshake.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     IF/ID handshake; in_instr, in_pc
//   rf_read1/rf_read2     register-file read addresses (rs / rt fields)
//   rf_data1/rf_data2     register-file read data (pre-write values)
//   wb_en/wb_reg/wb_data  write-back port, observed only, used for bypass
//   ex_load/ex_dest       EX-stage load destination, used for hazard check
//   flush                 synchronous squash of the stage
//   out_valid/out_ready   ID/EX handshake
//   out_*                 registered ID/EX bundle
// ---------------------------------------------------------------------------
module id_operand_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_instr,
    input  logic [DATA_W-1:0] in_pc,
    output logic [REG_AW-1:0] rf_read1,
    output logic [REG_AW-1:0] rf_read2,
    input  logic [DATA_W-1:0] rf_data1,
    input  logic [DATA_W-1:0] rf_data2,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ex_load,
    input  logic [REG_AW-1:0] ex_dest,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_instr,
    output logic [REG_AW-1:0] out_rs,
    output logic [REG_AW-1:0] out_rt,
    output logic [REG_AW-1:0] out_rd,
    output logic [DATA_W-1:0] out_rs_val,
    output logic [DATA_W-1:0] out_rt_val,
    output logic [DATA_W-1:0] out_imm
);

    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_XORI = 6'h0E;

    logic [REG_AW-1:0] w_rs;
    logic [REG_AW-1:0] w_rt;
    logic [REG_AW-1:0] w_rd;
    logic [5:0]        w_op;
    logic              w_hazard;
    logic              w_accept;
    logic [DATA_W-1:0] w_rs_val;
    logic [DATA_W-1:0] w_rt_val;
    logic [DATA_W-1:0] w_imm;

    logic              r_valid;
    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] r_instr;
    logic [REG_AW-1:0] r_rs;
    logic [REG_AW-1:0] r_rt;
    logic [REG_AW-1:0] r_rd;
    logic [DATA_W-1:0] r_rs_val;
    logic [DATA_W-1:0] r_rt_val;
    logic [DATA_W-1:0] r_imm;

    assign w_op = in_instr[31:26];
    assign w_rs = in_instr[25:21];
    assign w_rt = in_instr[20:16];
    assign w_rd = in_instr[15:11];

    assign rf_read1 = w_rs;
    assign rf_read2 = w_rt;

    // Both source fields are treated as used, regardless of opcode.
    assign w_hazard = in_valid && ex_load && (ex_dest != '0) &&
                      ((ex_dest == w_rs) || (ex_dest == w_rt));

    assign in_ready = !flush && !w_hazard && (!r_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    // The register file returns the pre-write value on a same-cycle write,
    // so a matching write-back must be bypassed here.
    always_comb begin
        w_rs_val = rf_data1;
        if (w_rs == '0) begin
            w_rs_val = '0;
        end else if (wb_en && (wb_reg == w_rs)) begin
            w_rs_val = wb_data;
        end
    end

    always_comb begin
        w_rt_val = rf_data2;
        if (w_rt == '0) begin
            w_rt_val = '0;
        end else if (wb_en && (wb_reg == w_rt)) begin
            w_rt_val = wb_data;
        end
    end

    // Logical immediates zero-extend; everything else sign-extends.
    always_comb begin
        if ((w_op == OP_ANDI) || (w_op == OP_ORI) || (w_op == OP_XORI)) begin
            w_imm = {{(DATA_W-16){1'b0}}, in_instr[15:0]};
        end else begin
            w_imm = {{(DATA_W-16){in_instr[15]}}, in_instr[15:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_pc     <= '0;
            r_instr  <= '0;
            r_rs     <= '0;
            r_rt     <= '0;
            r_rd     <= '0;
            r_rs_val <= '0;
            r_rt_val <= '0;
            r_imm    <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid  <= 1'b1;
            r_pc     <= in_pc;
            r_instr  <= in_instr;
            r_rs     <= w_rs;
            r_rt     <= w_rt;
            r_rd     <= w_rd;
            r_rs_val <= w_rs_val;
            r_rt_val <= w_rt_val;
            r_imm    <= w_imm;
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end else if (r_valid) begin
            // Held bundle: keep operands coherent with write-backs that
            // land while EX is back-pressuring us.
            if (wb_en && (wb_reg != '0) && (wb_reg == r_rs)) begin
                r_rs_val <= wb_data;
            end
            if (wb_en && (wb_reg != '0) && (wb_reg == r_rt)) begin
                r_rt_val <= wb_data;
            end
        end
    end

    assign out_valid  = r_valid;
    assign out_pc     = r_pc;
    assign out_instr  = r_instr;
    assign out_rs     = r_rs;
    assign out_rt     = r_rt;
    assign out_rd     = r_rd;
    assign out_rs_val = r_rs_val;
    assign out_rt_val = r_rt_val;
    assign out_imm    = r_imm;

endmodule

// File: tb/tb_id_operand_stage.sv
module tb_id_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [4:0]  rf_read1;
    logic [4:0]  rf_read2;
    logic [31:0] rf_data1;
    logic [31:0] rf_data2;
    logic        wb_en;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        ex_load;
    logic [4:0]  ex_dest;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [4:0]  out_rs;
    logic [4:0]  out_rt;
    logic [4:0]  out_rd;
    logic [31:0] out_rs_val;
    logic [31:0] out_rt_val;
    logic [31:0] out_imm;

    id_operand_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .rf_read1(rf_read1), .rf_read2(rf_read2),
        .rf_data1(rf_data1), .rf_data2(rf_data2),
        .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
        .ex_load(ex_load), .ex_dest(ex_dest),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr),
        .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
        .out_rs_val(out_rs_val), .out_rt_val(out_rt_val),
        .out_imm(out_imm)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rf1;
        logic [31:0] rf2;
        logic        we;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic        el;
        logic [4:0]  ed;
        logic        fl;
        logic        ordy;
    } stim_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] rsv;
        logic [31:0] rtv;
        logic [31:0] imm;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic stim_t mk(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                                 input logic [31:0] rf1, input logic [31:0] rf2,
                                 input logic we, input logic [4:0] wr, input logic [31:0] wd,
                                 input logic el, input logic [4:0] ed,
                                 input logic fl, input logic ordy);
        stim_t s;
        s.v = v; s.instr = instr; s.pc = pc; s.rf1 = rf1; s.rf2 = rf2;
        s.we = we; s.wr = wr; s.wd = wd; s.el = el; s.ed = ed; s.fl = fl; s.ordy = ordy;
        return s;
    endfunction

    // Operand as the instruction would see it: $0 reads zero, a write-back
    // in the same cycle wins over the (stale) register-file value.
    function automatic logic [31:0] operand(input logic [4:0] field, input logic [31:0] rf,
                                            input logic we, input logic [4:0] wr,
                                            input logic [31:0] wd);
        if (field == 5'd0) return 32'd0;
        if (we && wr == field) return wd;
        return rf;
    endfunction

    function automatic exp_t model(input stim_t s);
        exp_t e;
        logic [5:0] op;
        e.pc    = s.pc;
        e.instr = s.instr;
        e.rs    = s.instr[25:21];
        e.rt    = s.instr[20:16];
        e.rd    = s.instr[15:11];
        e.rsv   = operand(e.rs, s.rf1, s.we, s.wr, s.wd);
        e.rtv   = operand(e.rt, s.rf2, s.we, s.wr, s.wd);
        op      = s.instr[31:26];
        if (op == 6'd12 || op == 6'd13 || op == 6'd14)
            e.imm = 32'(s.instr[15:0]);
        else
            e.imm = 32'($signed(s.instr[15:0]));
        return e;
    endfunction

    // One clock cycle of stimulus; the queue always holds exactly the
    // bundle the DUT should be presenting (plus a freshly accepted one
    // between this call and the monitor's pop).
    task automatic step(input stim_t s, output logic acc);
        logic mv, haz, rdy;
        exp_t e;
        @(negedge clk);
        chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        in_valid = s.v;  in_instr = s.instr; in_pc = s.pc;
        rf_data1 = s.rf1; rf_data2 = s.rf2;
        wb_en = s.we; wb_reg = s.wr; wb_data = s.wd;
        ex_load = s.el; ex_dest = s.ed; flush = s.fl; out_ready = s.ordy;
        #1;
        mv  = exp_q.size() != 0;
        haz = s.v && s.el && s.ed != 5'd0 &&
              (s.ed == s.instr[25:21] || s.ed == s.instr[20:16]);
        rdy = !s.fl && !haz && (!mv || s.ordy);
        chk("in_ready", 32'(in_ready), 32'(rdy));
        chk("rf_read1", 32'(rf_read1), 32'(s.instr[25:21]));
        chk("rf_read2", 32'(rf_read2), 32'(s.instr[20:16]));
        acc = s.v && rdy;
        if (acc) begin
            exp_q.push_back(model(s));
        end else if (mv && !s.ordy) begin
            if (s.fl) begin
                exp_q.delete(0);
            end else begin
                e = exp_q[0];
                if (s.we && s.wr != 5'd0 && s.wr == e.rs) e.rsv = s.wd;
                if (s.we && s.wr != 5'd0 && s.wr == e.rt) e.rtv = s.wd;
                exp_q[0] = e;
            end
        end
    endtask

    // Monitor: compares each bundle as the execute stage takes it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_bundle_pc", out_pc, 32'hxxxx_xxxx);
                end else begin
                    e = exp_q.pop_front();
                    chk("mon_pc",     out_pc,            e.pc);
                    chk("mon_instr",  out_instr,         e.instr);
                    chk("mon_rs",     32'(out_rs),       32'(e.rs));
                    chk("mon_rt",     32'(out_rt),       32'(e.rt));
                    chk("mon_rd",     32'(out_rd),       32'(e.rd));
                    chk("mon_rs_val", out_rs_val,        e.rsv);
                    chk("mon_rt_val", out_rt_val,        e.rtv);
                    chk("mon_imm",    out_imm,           e.imm);
                end
            end
        end
    end

    initial begin
        logic        acc;
        logic        pend;
        stim_t       s;
        logic [31:0] pc_ctr;
        logic [31:0] tmp;
        logic [5:0]  ops [6];
        logic [5:0]  op;
        logic [31:0] held_pc;

        ops[0] = 6'h00; ops[1] = 6'h08; ops[2] = 6'h0C;
        ops[3] = 6'h0D; ops[4] = 6'h0E; ops[5] = 6'h23;

        rst_n = 1'b0;
        in_valid = 0; in_instr = 0; in_pc = 0; rf_data1 = 0; rf_data2 = 0;
        wb_en = 0; wb_reg = 0; wb_data = 0; ex_load = 0; ex_dest = 0;
        flush = 0; out_ready = 0;
        repeat (3) @(negedge clk);
        chk("reset_out_valid",  32'(out_valid), 32'd0);
        chk("reset_out_pc",     out_pc,         32'd0);
        chk("reset_out_rs_val", out_rs_val,     32'd0);
        chk("reset_out_imm",    out_imm,        32'd0);
        rst_n = 1'b1;

        // Bypass from write-back onto rs.
        step(mk(1, 32'h012A4020, 32'h100, 32'h11, 32'h22, 1, 5'd9, 32'hDEAD, 0, 0, 0, 1), acc);
        // $0 source ignores a write-back to $0.
        step(mk(1, 32'h000A4020, 32'h104, 32'h55, 32'h66, 1, 5'd0, 32'hFFFF_FFFF, 0, 0, 0, 1), acc);
        chk("bypass_rs_val", out_rs_val, 32'hDEAD);
        chk("bypass_rt_val", out_rt_val, 32'h22);
        chk("bypass_rd",     32'(out_rd), 32'd8);
        // Load-use against $9: stall, previous bundle drains.
        step(mk(1, 32'h01254020, 32'h108, 32'h1, 32'h2, 0, 0, 0, 1, 5'd9, 0, 1), acc);
        chk("zero_rs_val", out_rs_val, 32'd0);
        chk("loaduse_in_ready", 32'(in_ready), 32'd0);
        step(mk(1, 32'h01254020, 32'h108, 32'h1, 32'h2, 0, 0, 0, 0, 5'd9, 0, 1), acc);
        chk("loaduse_bubble", 32'(out_valid), 32'd0);
        // Back-pressure with a write-back to the held rt ($5).
        step(mk(1, 32'h35288000, 32'h10C, 0, 0, 1, 5'd5, 32'h1234, 0, 0, 0, 0), acc);
        chk("loaduse_accepted", 32'(out_valid), 32'd1);
        step(mk(1, 32'h35288000, 32'h10C, 0, 0, 0, 0, 0, 0, 0, 0, 0), acc);
        chk("hold_rt_val", out_rt_val, 32'h1234);
        chk("hold_rs_val", out_rs_val, 32'h1);
        chk("hold_pc",     out_pc,     32'h108);
        chk("hold_in_ready", 32'(in_ready), 32'd0);
        // ori then addi with imm 0x8000, then a flushed instruction.
        step(mk(1, 32'h35288000, 32'h10C, 0, 0, 0, 0, 0, 0, 0, 0, 1), acc);
        step(mk(1, 32'h21288000, 32'h110, 0, 0, 0, 0, 0, 0, 0, 0, 1), acc);
        chk("ori_imm", out_imm, 32'h0000_8000);
        step(mk(1, 32'h2000_0007, 32'h114, 0, 0, 0, 0, 0, 0, 0, 1, 1), acc);
        chk("addi_imm", out_imm, 32'hFFFF_8000);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), acc);
        chk("flush_not_captured", 32'(out_valid), 32'd0);

        // Randomized traffic with small register indices to force collisions.
        pend   = 1'b0;
        pc_ctr = 32'h1000;
        s      = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3000; i++) begin
            if (!pend) begin
                tmp = $urandom();
                op  = ($urandom_range(0, 7) == 0) ? tmp[31:26] : ops[$urandom_range(0, 5)];
                s.instr = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                           5'($urandom_range(0, 3)), tmp[10:0]};
                s.pc = pc_ctr;
                pc_ctr += 4;
                s.v = ($urandom_range(0, 3) != 0);
            end
            s.rf1  = $urandom();
            s.rf2  = $urandom();
            s.we   = $urandom_range(0, 1) == 1;
            s.wr   = 5'($urandom_range(0, 3));
            s.wd   = $urandom();
            s.el   = $urandom_range(0, 2) == 0;
            s.ed   = 5'($urandom_range(0, 3));
            s.fl   = $urandom_range(0, 11) == 0;
            s.ordy = $urandom_range(0, 2) != 0;
            step(s, acc);
            pend = s.v && !acc && !s.fl;
        end

        repeat (3) step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), acc);
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset while a bundle is being held.
        step(mk(1, 32'h012A4020, 32'h200, 32'h77, 32'h88, 0, 0, 0, 0, 0, 0, 1), acc);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), acc);
        held_pc = out_pc;
        chk("pre_reset_pc", held_pc, 32'h200);
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_out_valid",  32'(out_valid), 32'd0);
        chk("async_reset_out_rs_val", out_rs_val,     32'd0);
        chk("async_reset_out_pc",     out_pc,         32'd0);
        exp_q.delete();
        @(negedge clk);
        #5;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
